layer_2_channel_packer: RTL
===========================

// Module: layer_2_channel_packer
// PURPOSE
//  Upstream producer for the layer-2 feature-map blocks: accepts a channel-interleaved
//  32-bit float stream (16 channels per pixel, channel 0 first) and packs each pixel into
//  one 512-bit word for the per-featuremap Conv2D3x3 banks. It tracks raster position over
//  an IMG_SIZE x IMG_SIZE map and flags end-of-line and end-of-frame. Consumers have no
//  ready, so this block never stalls downstream.
// PARAMETERS
//  DATA_WIDTH  32   width of one channel value (IEEE-754 single)
//  NUM_CH      16   channels per packed word; DATA_OUT_WIDTH = DATA_WIDTH*NUM_CH = 512
//  IMG_SIZE    208  feature-map width and height in pixels
// PORTS
//  Clk        in   1    clock
//  Rst        in   1    asynchronous reset, active-low
//  clear      in   1    synchronous restart: drop partial pixel, zero position counters
//  data_in    in   32   one channel value
//  valid_in   in   1    data_in valid this cycle; always accepted (ready_out=1 outside reset)
//  ready_out  out  1    upstream may present data
//  data_out   out  512  packed pixel; channel k in bits [32k+31:32k]
//  valid_out  out  1    one-cycle pulse: data_out holds a new complete pixel
//  eol        out  1    pulses with valid_out on the last pixel of a row (col == IMG_SIZE-1)
//  eof        out  1    pulses with valid_out on the last pixel of the frame
// BEHAVIOUR
//  - Reset (Rst=0, async): data_out=0, valid_out=0, eol=0, eof=0, ready_out=0,
//    ch_cnt=0, col=0, row=0, assembly register=0. ready_out=1 from the first edge after release.
//  - Accept: each cycle with valid_in=1 and clear=0 writes data_in into lane ch_cnt of the
//    assembly register; ch_cnt increments, wrapping NUM_CH-1 -> 0.
//  - Completion: the accept with ch_cnt==NUM_CH-1 copies the full word (including this
//    value) to data_out and drives valid_out=1 on the next cycle; latency 1 cycle
//    from the 16th accepted value. data_out holds until the next completion.
//  - Back-to-back pixels at full rate (valid_in held high): valid_out every 16 cycles,
//    no bubbles; the assembly register is reused immediately (data_out is a separate register).
//  - Position: on each completion col increments; col==IMG_SIZE-1 -> col=0, eol=1, row++;
//    additionally row==IMG_SIZE-1 -> row=0, eof=1. eol/eof are single-cycle, coincident with valid_out.
//  - valid_in=0 gaps: state held; the partial pixel is preserved indefinitely.
//  - clear=1: ch_cnt, col, row -> 0; partial pixel discarded; a coincident valid_in word is
//    dropped (clear wins). A completion already registered still emits valid_out that
//    cycle; data_out is not cleared.
//  - Mid-operation Rst: all state returns to reset values; no partial output is emitted.
//  - Counter widths: ch_cnt $clog2(NUM_CH); col/row $clog2(IMG_SIZE). No arithmetic on data.
// STRUCTURE
//  - Shared package/header layer_params: DATA_WIDTH, NUM_CH, IMG_SIZE, DATA_OUT_WIDTH,
//    counter-width localparams; reused by the featuremap and conv modules.
//  - One sub-module: raster_pos_counter (col/row counters with eol/eof generation),
//    reused by the downstream unpacker. Lane write and output register stay in this module.
// TESTING
//  1 Reset: hold Rst=0, drive valid_in -> all outputs 0, ready_out=0; release -> ready_out=1.
//  2 Single pixel: send 32'h3f800000+k for k=0..15 back-to-back -> valid_out one cycle after
//    the 16th; data_out[31:0]=3f800000, data_out[511:480]=3f80000f; eol=eof=0.
//  3 Gapped input: same 16 values with valid_in toggling 1/0 -> identical data_out, single pulse.
//  4 Row/frame wrap (IMG_SIZE=4 override): stream 16 pixels -> eol on pixels 3,7,11,15,
//    eof only on pixel 15; pixel 16 has col=row=0 and eol=eof=0.
//  5 clear mid-pixel: 7 values, clear=1 with valid_in=1, then 16 values -> exactly one
//    valid_out, data_out lane 0 = first post-clear value.
//  6 Async Rst asserted after 10 values mid-frame -> outputs zero immediately; next 16
//    values yield one pixel at col=0,row=0.

Source files
------------

// File: rtl/layer_params.sv
// Shared dimensions for the layer-2 feature-map datapath (packer, featuremaps, conv banks).
package layer_params;

  localparam int L2_DATA_WIDTH     = 32;
  localparam int L2_NUM_CH         = 16;
  localparam int L2_IMG_SIZE       = 208;
  localparam int L2_DATA_OUT_WIDTH = L2_DATA_WIDTH * L2_NUM_CH;

  // Counter width able to index 0..n-1; never narrower than one bit.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int L2_CH_CNT_WIDTH = cnt_width(L2_NUM_CH);
  localparam int L2_POS_WIDTH    = cnt_width(L2_IMG_SIZE);

endpackage

// File: rtl/raster_pos_counter.sv
// Raster position tracker: advances col/row once per pixel and pulses eol/eof
// in the cycle after the advance, aligned with a registered pixel output.
module raster_pos_counter
  import layer_params::*;
#(
  parameter int IMG_SIZE = L2_IMG_SIZE,
  parameter int POS_W    = cnt_width(IMG_SIZE)
) (
  input  logic Clk,
  input  logic Rst,
  input  logic clear,
  input  logic i_advance,
  output logic o_eol,
  output logic o_eof
);

  logic [POS_W-1:0] r_col;
  logic [POS_W-1:0] r_row;
  logic             r_eol;
  logic             r_eof;
  logic             w_last_col;
  logic             w_last_row;

  assign w_last_col = (r_col == POS_W'(IMG_SIZE - 1));
  assign w_last_row = (r_row == POS_W'(IMG_SIZE - 1));

  // Column/row counters with wrap, and single-cycle line/frame end flags.
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      r_col <= '0;
      r_row <= '0;
      r_eol <= 1'b0;
      r_eof <= 1'b0;
    end else if (clear) begin
      r_col <= '0;
      r_row <= '0;
      r_eol <= 1'b0;
      r_eof <= 1'b0;
    end else if (i_advance) begin
      r_eol <= w_last_col;
      r_eof <= w_last_col & w_last_row;
      if (w_last_col) begin
        r_col <= '0;
        r_row <= w_last_row ? '0 : (r_row + POS_W'(1));
      end else begin
        r_col <= r_col + POS_W'(1);
      end
    end else begin
      r_eol <= 1'b0;
      r_eof <= 1'b0;
    end
  end

  assign o_eol = r_eol;
  assign o_eof = r_eof;

endmodule

// File: rtl/layer_2_channel_packer.sv
// Packs a channel-interleaved float stream (channel 0 first) into one wide word
// per pixel and flags end-of-line / end-of-frame. Never stalls the consumer side.
module layer_2_channel_packer
  import layer_params::*;
#(
  parameter int DATA_WIDTH = L2_DATA_WIDTH,
  parameter int NUM_CH     = L2_NUM_CH,
  parameter int IMG_SIZE   = L2_IMG_SIZE
) (
  input  logic                         Clk,
  input  logic                         Rst,
  input  logic                         clear,
  input  logic [DATA_WIDTH-1:0]        data_in,
  input  logic                         valid_in,
  output logic                         ready_out,
  output logic [DATA_WIDTH*NUM_CH-1:0] data_out,
  output logic                         valid_out,
  output logic                         eol,
  output logic                         eof
);

  localparam int CH_W = cnt_width(NUM_CH);

  logic [NUM_CH-1:0][DATA_WIDTH-1:0] r_asm;
  logic [NUM_CH-1:0][DATA_WIDTH-1:0] w_asm_next;
  logic [DATA_WIDTH*NUM_CH-1:0]      r_data_out;
  logic [CH_W-1:0]                   r_ch_cnt;
  logic                              r_valid_out;
  logic                              r_ready_out;
  logic                              w_last_lane;
  logic                              w_complete;

  assign w_last_lane = (r_ch_cnt == CH_W'(NUM_CH - 1));
  assign w_complete  = valid_in & ~clear & w_last_lane;

  // Assembly word with the incoming value dropped into the current lane.
  always_comb begin
    w_asm_next           = r_asm;
    w_asm_next[r_ch_cnt] = data_in;
  end

  // Lane write, channel counter, and the separate output register so the
  // assembly word can be reused immediately by the next pixel.
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      r_asm       <= '0;
      r_data_out  <= '0;
      r_ch_cnt    <= '0;
      r_valid_out <= 1'b0;
      r_ready_out <= 1'b0;
    end else begin
      r_ready_out <= 1'b1;
      if (clear) begin
        r_asm       <= '0;
        r_ch_cnt    <= '0;
        r_valid_out <= 1'b0;
      end else if (valid_in) begin
        r_asm       <= w_asm_next;
        r_ch_cnt    <= w_last_lane ? '0 : (r_ch_cnt + CH_W'(1));
        r_valid_out <= w_last_lane;
        if (w_last_lane) begin
          r_data_out <= w_asm_next;
        end else begin
          r_data_out <= r_data_out;
        end
      end else begin
        r_valid_out <= 1'b0;
      end
    end
  end

  raster_pos_counter #(
    .IMG_SIZE (IMG_SIZE)
  ) u_pos (
    .Clk       (Clk),
    .Rst       (Rst),
    .clear     (clear),
    .i_advance (w_complete),
    .o_eol     (eol),
    .o_eof     (eof)
  );

  assign data_out  = r_data_out;
  assign valid_out = r_valid_out;
  assign ready_out = r_ready_out;

endmodule
